multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. Sequences one instruction over 3–5 cycles through a shared ALU, a single unified memory port and the register file. Drives the ALU-operation code consumed by the ALU control decoder (00 add, 01 sub, 10 decode funct fields), the datapath mux selects and all architectural write enables. Supports lw, sw, R-type ALU, I-type ALU, beq and jal, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the state to FETCH.
- op  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable; equals pc_update | (branch & zero).
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a  out  2  ALU A select: 00 PC, 01 OldPC, 10 rs1 register.
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 ImmExt, 10 constant 4.
- alu_op  out  2  00 add, 01 sub, 10 decode funct fields.
- instr_retired  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- Moore FSM. Outputs decode from the state register, except for the terms gated by mem_ready and zero. Any output not listed for a state is 0.
- **FETCH**: alu_src_b=10, result_src=10; ir_write = pc_update = mem_ready. On mem_ready go to DECODE, otherwise hold.
- **DECODE**: alu_src_a=01, alu_src_b=01 (branch target goes to ALUOut). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other value → illegal (see Configuration).
- **MEMADR**: alu_src_a=10, alu_src_b=01. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- **MEMREAD**: adr_src=1. Holds until mem_ready, then goes to MEMWB.
- **MEMWB**: result_src=01, reg_write=1, instr_retired=1. Goes to FETCH.
- **MEMWRITE**: adr_src=1, mem_write=1, held high until mem_ready. On mem_ready, instr_retired=1 and go to FETCH.
- **EXECUTER**: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- **EXECUTEI**: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- **ALUWB**: reg_write=1, instr_retired=1. Goes to FETCH.
- **BEQ**: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1, instr_retired=1. Goes to FETCH.
- **JAL**: alu_src_a=01, alu_src_b=10, pc_update=1. Goes to ALUWB, which writes PC+4 to rd.
- Only these states are reachable. Unused state encodings return to FETCH.

## Timing
- State register is the only storage; no output is registered.
- While reset is high, pc_write, ir_write, mem_write, reg_write and instr_retired are forced to 0 combinationally.
- On reset deassertion the FSM is in FETCH. First fetch completes at the first edge where mem_ready=1.
- Zero-wait-state instruction latency in cycles:
  - lw: 5
  - sw: 4
  - R/I ALU: 4
  - beq: 3
  - jal: 4
- Every cycle mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. While stalled, all select outputs are stable and all write enables except mem_write are 0.
- Reset asserted mid-instruction aborts it immediately. No register or memory write occurs once reset is high.
- mem_ready is ignored in all other states.

## Configuration
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- **Defined**: an unknown op in DECODE goes to TRAP.
  - TRAP drives all enables 0 and asserts the extra output illegal_op=1.
  - TRAP holds until reset.
- **Undefined**: an unknown op in DECODE returns to FETCH as a no-op.
  - instr_retired=1 in that DECODE cycle.
  - The illegal_op port does not exist.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - state enum state_t
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUOp, result-source and ALU-source encodings, shared with the ALU control decoder
- One sub-module, multicycle_opclass: combinational op-to-class decoder feeding the DECODE transition.

## Test plan
- add x3,x1,x2 with mem_ready tied 1: FETCH→DECODE→EXECUTER→ALUWB. alu_op=10 in EXECUTER; reg_write and instr_retired high in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD: 7 cycles total; adr_src=1 throughout MEMREAD; reg_write only in MEMWB with result_src=01.
- beq with zero=1, then zero=0: pc_write=1 in BEQ for the first and 0 for the second; alu_op=01 in both.
- jal: pc_write=1 in the JAL cycle; reg_write=1 in the following ALUWB cycle.
- sw with reset asserted in MEMWRITE before mem_ready: mem_write drops to 0 immediately; state is FETCH after release.
- op=1111111 with the macro defined: illegal_op=1 and all enables 0 until reset. Without the macro: instr_retired pulses and the next cycle is FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control path: FSM state
// encoding, opcode constants, instruction classes and the select / ALUOp
// encodings that the datapath and the ALU control decoder also use.
package riscv_ctrl_pkg;

  // Main control FSM states; encodings 12..15 are unused.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Instruction classes produced by the opcode decoder.
  typedef enum logic [2:0] {
    CLS_MEM     = 3'd0,
    CLS_ALUR    = 3'd1,
    CLS_ALUI    = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } opclass_t;

  // Opcodes (instr[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp encodings.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux encodings.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A source encodings.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B source encodings.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_opclass.sv
// multicycle_opclass
// Combinational opcode-to-class decoder feeding the DECODE transition of
// multicycle_ctrl.
//   op      in  7  instr[6:0]
//   opclass out 3  instruction class (opclass_t)
module multicycle_opclass
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output opclass_t   opclass
);

  // Map the opcode onto the class that selects the post-DECODE state.
  always_comb begin
    opclass = CLS_ILLEGAL;
    case (op)
      OP_LW,
      OP_SW:   opclass = CLS_MEM;
      OP_R:    opclass = CLS_ALUR;
      OP_I:    opclass = CLS_ALUI;
      OP_BEQ:  opclass = CLS_BEQ;
      OP_JAL:  opclass = CLS_JAL;
      default: opclass = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Main control FSM of the multicycle RV32I core (lw, sw, R/I ALU, beq, jal).
// Moore machine; only pc/ir write enables (mem_ready), the branch PC load
// (zero) and the store completion pulse (mem_ready) depend on inputs.
// Ports:
//   clk, reset (async, active-high)      op[6:0], zero, mem_ready
//   pc_write, adr_src, ir_write, mem_write, reg_write, result_src[1:0],
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], instr_retired
//   illegal_op (only with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined)
// Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to a
// TRAP state held until reset; otherwise they retire as a no-op in DECODE.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       instr_retired
);

  state_t     state_r;
  state_t     state_nxt_s;
  opclass_t   opclass_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       retired_s;

  multicycle_opclass u_opclass (
    .op      (op),
    .opclass (opclass_s)
  );

  // State register; reset lands in FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    state_nxt_s = S_FETCH;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    retired_s   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
        if (mem_ready) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch target into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opclass_s)
          CLS_MEM:  state_nxt_s = S_MEMADR;
          CLS_ALUR: state_nxt_s = S_EXECUTER;
          CLS_ALUI: state_nxt_s = S_EXECUTEI;
          CLS_BEQ:  state_nxt_s = S_BEQ;
          CLS_JAL:  state_nxt_s = S_JAL;
          default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            state_nxt_s = S_TRAP;
`else
            state_nxt_s = S_FETCH;
            retired_s   = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        // op[5] separates sw (0100011) from lw (0000011).
        if (op[5]) begin
          state_nxt_s = S_MEMWRITE;
        end else begin
          state_nxt_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) begin
          state_nxt_s = S_MEMWB;
        end else begin
          state_nxt_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        retired_s   = mem_ready;
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMWRITE;
        end
      end
      S_EXECUTER: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_FUNCT;
        state_nxt_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_nxt_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        retired_s   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_SUB;
        branch_s    = 1'b1;
        retired_s   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target); ALU computes OldPC+4 for the link write.
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        pc_update_s = 1'b1;
        state_nxt_s = S_ALUWB;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        state_nxt_s = S_TRAP;
      end
`endif
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Architectural enables are squashed while reset is high so nothing is
  // written during an aborted instruction.
  assign pc_write      = ~reset & (pc_update_s | (branch_s & zero));
  assign ir_write      = ~reset & ir_write_s;
  assign mem_write     = ~reset & mem_write_s;
  assign reg_write     = ~reset & reg_write_s;
  assign instr_retired = ~reset & retired_s;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = (state_r == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Each cycle the stimulus drives inputs
// and pushes the hand-written expected output vector; a monitor pops and
// compares on the falling edge.
// Vector layout: {pc_write, adr_src, ir_write, mem_write, reg_write,
//                 result_src[1:0], alu_src_a[1:0], alu_src_b[1:0],
//                 alu_op[1:0], instr_retired, illegal_op}
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_retired;
  logic       ill_s;
  logic [14:0] act_s;

  typedef struct {
    logic [14:0] vec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  //                                pcw   adr   irw   mw    rw    rs     a      b      aop    ret   ill
  localparam logic [14:0] V_RST   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_FGO   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_FSTL  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_DEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_DECNOP= {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] V_EXR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [14:0] V_EXI   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
  localparam logic [14:0] V_ALUWB = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] V_MADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_MRD   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_MWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] V_MWGO  = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] V_MWSTL = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_BEQT  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
  localparam logic [14:0] V_BEQN  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b1, 1'b0};
  localparam logic [14:0] V_JAL   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] V_TRAP  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

  localparam logic [6:0] OP_BAD = 7'b1111111;

  multicycle_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    .illegal_op    (ill_s),
`endif
    .instr_retired (instr_retired)
  );

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign ill_s = 1'b0;
`endif

  assign act_s = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                  alu_src_a, alu_src_b, alu_op, instr_retired, ill_s};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare presented outputs against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (act_s !== e.vec) begin
          n_miss++;
          $display("FAIL %s: got %b expected %b", e.name, act_s, e.vec);
        end
      end
    end
  end

  // Drive one cycle of inputs, queue its expected outputs, advance a cycle.
  task automatic step(input logic rst_v, input logic [6:0] op_v, input logic zero_v,
                      input logic mr_v, input logic [14:0] exp_v, input string nm);
    exp_t e;
    reset     = rst_v;
    op        = op_v;
    zero      = zero_v;
    mem_ready = mr_v;
    e.vec  = exp_v;
    e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = OP_R; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Reset: FETCH selects visible, every enable squashed despite mem_ready=1.
    step(1'b1, OP_R, 1'b0, 1'b1, V_RST, "reset_state");

    // add x3,x1,x2: 4 cycles.
    step(1'b0, OP_R, 1'b0, 1'b1, V_FGO,   "add_fetch");
    step(1'b0, OP_R, 1'b0, 1'b1, V_DEC,   "add_decode");
    step(1'b0, OP_R, 1'b0, 1'b1, V_EXR,   "add_executer");
    step(1'b0, OP_R, 1'b0, 1'b1, V_ALUWB, "add_aluwb");

    // addi with one fetch stall.
    step(1'b0, OP_I, 1'b0, 1'b0, V_FSTL,  "addi_fetch_stall");
    step(1'b0, OP_I, 1'b0, 1'b1, V_FGO,   "addi_fetch");
    step(1'b0, OP_I, 1'b0, 1'b1, V_DEC,   "addi_decode");
    step(1'b0, OP_I, 1'b0, 1'b1, V_EXI,   "addi_executei");
    step(1'b0, OP_I, 1'b0, 1'b1, V_ALUWB, "addi_aluwb");

    // lw with two MEMREAD wait states: 7 cycles.
    step(1'b0, OP_LW, 1'b0, 1'b1, V_FGO,  "lw_fetch");
    step(1'b0, OP_LW, 1'b0, 1'b1, V_DEC,  "lw_decode");
    step(1'b0, OP_LW, 1'b0, 1'b1, V_MADR, "lw_memadr");
    step(1'b0, OP_LW, 1'b0, 1'b0, V_MRD,  "lw_memread_stall1");
    step(1'b0, OP_LW, 1'b0, 1'b0, V_MRD,  "lw_memread_stall2");
    step(1'b0, OP_LW, 1'b0, 1'b1, V_MRD,  "lw_memread_done");
    step(1'b0, OP_LW, 1'b0, 1'b0, V_MWB,  "lw_memwb");

    // sw zero-wait: 4 cycles.
    step(1'b0, OP_SW, 1'b0, 1'b1, V_FGO,  "sw_fetch");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_DEC,  "sw_decode");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MADR, "sw_memadr");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MWGO, "sw_memwrite");

    // beq taken then not taken.
    step(1'b0, OP_BEQ, 1'b1, 1'b1, V_FGO,  "beq1_fetch");
    step(1'b0, OP_BEQ, 1'b1, 1'b1, V_DEC,  "beq1_decode");
    step(1'b0, OP_BEQ, 1'b1, 1'b0, V_BEQT, "beq1_taken");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, V_FGO,  "beq0_fetch");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, V_DEC,  "beq0_decode");
    step(1'b0, OP_BEQ, 1'b0, 1'b1, V_BEQN, "beq0_not_taken");

    // jal.
    step(1'b0, OP_JAL, 1'b0, 1'b1, V_FGO,   "jal_fetch");
    step(1'b0, OP_JAL, 1'b0, 1'b1, V_DEC,   "jal_decode");
    step(1'b0, OP_JAL, 1'b0, 1'b0, V_JAL,   "jal_jal");
    step(1'b0, OP_JAL, 1'b0, 1'b1, V_ALUWB, "jal_aluwb");

    // sw aborted by reset while MEMWRITE is stalled.
    step(1'b0, OP_SW, 1'b0, 1'b1, V_FGO,   "swrst_fetch");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_DEC,   "swrst_decode");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MADR,  "swrst_memadr");
    step(1'b0, OP_SW, 1'b0, 1'b0, V_MWSTL, "swrst_memwrite_stall");
    step(1'b1, OP_SW, 1'b0, 1'b1, V_RST,   "swrst_reset_abort");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_FGO,   "swrst_fetch_after");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_DEC,   "swrst_decode_after");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MADR,  "swrst_memadr_after");
    step(1'b0, OP_SW, 1'b0, 1'b1, V_MWGO,  "swrst_memwrite_after");

    // Unknown opcode.
    step(1'b0, OP_BAD, 1'b0, 1'b1, V_FGO,   "bad_fetch");
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    step(1'b0, OP_BAD, 1'b0, 1'b1, V_DEC,   "bad_decode");
    step(1'b0, OP_BAD, 1'b0, 1'b1, V_TRAP,  "bad_trap1");
    step(1'b0, OP_R,   1'b1, 1'b1, V_TRAP,  "bad_trap2");
    step(1'b0, OP_R,   1'b1, 1'b0, V_TRAP,  "bad_trap3");
    step(1'b1, OP_R,   1'b0, 1'b1, V_RST,   "bad_reset");
    step(1'b0, OP_R,   1'b0, 1'b1, V_FGO,   "bad_fetch_after");
`else
    step(1'b0, OP_BAD, 1'b0, 1'b1, V_DECNOP, "bad_decode_nop");
    step(1'b0, OP_R,   1'b0, 1'b1, V_FGO,    "bad_fetch_after");
`endif
    step(1'b0, OP_R, 1'b0, 1'b1, V_DEC, "final_decode");

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
